// File: rtl/engine_pkg.sv
// engine_pkg: shared constants and types for the dot-product sequencer.
// Holds lane/width constants, plane bookkeeping and the FSM state enum.
package engine_pkg;

    localparam int LANES        = 4;
    localparam int DATA_W       = 16;
    localparam int WGT_W        = 5;
    localparam int NUM_PLANES   = WGT_W;
    localparam int SIGN_PLANE   = WGT_W - 1;
    localparam int SHIFT_W      = 3;
    localparam int FLUSH_CYCLES = 2;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ISSUE,
        FLUSH,
        RESP
    } seq_state_t;

endpackage

// File: rtl/engine_plane_mask.sv
// engine_plane_mask: per-lane select of activation or zero from one weight bit.
// Ports: act/wgt packed lanes, plane index, enable; pp = masked partial products.
module engine_plane_mask #(
    parameter int LANES   = engine_pkg::LANES,
    parameter int DATA_W  = engine_pkg::DATA_W,
    parameter int WGT_W   = engine_pkg::WGT_W,
    parameter int SHIFT_W = engine_pkg::SHIFT_W
) (
    input  logic [LANES*DATA_W-1:0] act,
    input  logic [LANES*WGT_W-1:0]  wgt,
    input  logic [SHIFT_W-1:0]      plane,
    input  logic                    en,
    output logic [LANES*DATA_W-1:0] pp
);
    import engine_pkg::*;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [WGT_W-1:0] w;
        logic             sel;

        assign w = wgt[j*WGT_W +: WGT_W];
        // Out-of-range plane indices select nothing.
        assign sel = en && (int'(plane) < WGT_W) && w[plane];
        assign pp[j*DATA_W +: DATA_W] =
            sel ? act[j*DATA_W +: DATA_W] : '0;
    end

endmodule

// File: rtl/engine_dotp_sequencer.sv
// engine_dotp_sequencer: bit-serial operand sequencer feeding the accumulator.
// Ports: req_* request in, pp_data/shift_amount/acc_init to adder, acc_sum back, rsp_* out.
module engine_dotp_sequencer #(
    parameter int LANES  = engine_pkg::LANES,
    parameter int DATA_W = engine_pkg::DATA_W,
    parameter int WGT_W  = engine_pkg::WGT_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [LANES*DATA_W-1:0]          req_act,
    input  logic [LANES*WGT_W-1:0]           req_wgt,
    output logic [LANES*DATA_W-1:0]          pp_data,
    output logic [engine_pkg::SHIFT_W-1:0]   shift_amount,
    output logic                             acc_init,
    input  logic [DATA_W-1:0]                acc_sum,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_W-1:0]                rsp_sum
);
    import engine_pkg::*;

    localparam logic [SHIFT_W-1:0] LAST_PLANE = SHIFT_W'(WGT_W - 1);

    seq_state_t state;
    seq_state_t state_nx;

    logic [SHIFT_W-1:0]      plane_q;
    logic                    flush_q;
    logic [LANES*DATA_W-1:0] act_q;
    logic [LANES*WGT_W-1:0]  wgt_q;
    logic [SHIFT_W-1:0]      shift_q;
    logic [DATA_W-1:0]       rsp_sum_q;
    logic                    issue_en;
    logic                    capture;
    logic                    last_plane;
    logic                    last_flush;

    assign last_plane = (plane_q == LAST_PLANE);
    assign last_flush = flush_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (req_valid) state_nx = INIT;
            INIT:    state_nx = ISSUE;
            ISSUE:   if (last_plane) state_nx = FLUSH;
            FLUSH:   if (last_flush) state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready = 1'b0;
        acc_init  = 1'b0;
        issue_en  = 1'b0;
        rsp_valid = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE:    req_ready = 1'b1;
            INIT:    acc_init  = 1'b1;
            ISSUE:   issue_en  = 1'b1;
            FLUSH:   capture   = last_flush;
            RESP:    rsp_valid = 1'b1;
            default: req_ready = 1'b0;
        endcase
    end

    // Operand capture, plane/flush counters, delayed shift, result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q     <= '0;
            wgt_q     <= '0;
            plane_q   <= '0;
            flush_q   <= 1'b0;
            shift_q   <= '0;
            rsp_sum_q <= '0;
        end else begin
            if (req_ready && req_valid) begin
                act_q <= req_act;
                wgt_q <= req_wgt;
            end
            if (issue_en && !last_plane) begin
                plane_q <= plane_q + SHIFT_W'(1);
            end else begin
                plane_q <= '0;
            end
            flush_q <= (state == FLUSH) && !flush_q;
            // The adder registers data one cycle before shifting it.
            shift_q <= issue_en ? plane_q : '0;
            if (capture) begin
                rsp_sum_q <= acc_sum;
            end
        end
    end

    engine_plane_mask #(
        .LANES   (LANES),
        .DATA_W  (DATA_W),
        .WGT_W   (WGT_W),
        .SHIFT_W (SHIFT_W)
    ) u_mask (
        .act   (act_q),
        .wgt   (wgt_q),
        .plane (plane_q),
        .en    (issue_en),
        .pp    (pp_data)
    );

    assign shift_amount = shift_q;
    assign rsp_sum      = rsp_sum_q;

endmodule

// File: doc/engine_dotp_sequencer.md
# engine_dotp_sequencer

Bit-serial operand sequencer that sits directly upstream of the engine accumulator/adder stage. It accepts one 4-lane dot-product request: four 16-bit activations and four 5-bit signed weights. It then drives the adder with one masked bit-plane of partial products per cycle, plus the matching shift amount and the init pulse. It returns the accumulated 16-bit result through a valid/ready response port.

## Interface
- `LANES`, default 4: number of activation/weight lanes; fixed by the adder, which sums exactly 4.
- `DATA_W`, default 16: activation, partial-product and accumulator width.
- `WGT_W`, default 5: signed weight width; the plane count equals `WGT_W`, and the MSB plane is the sign plane.

Clocking and reset (already decided): one clock; reset is asynchronous and active-high.

- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous reset, active-high. The adder's reset is driven from the same source.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_act` in LANES×DATA_W: activations; lane j is bits [16j+15:16j].
- `req_wgt` in LANES×WGT_W: two's-complement weights.
- `pp_data` out LANES×DATA_W: masked partial products, one bit-plane per cycle, to the adder's data inputs.
- `shift_amount` out 3: plane index for the adder's second stage; value 4 means subtract.
- `acc_init` out 1: clears the adder pipeline and accumulator.
- `acc_sum` in DATA_W: adder accumulator output.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_sum` out DATA_W: registered result.

## Operation
- **FSM states:** IDLE → INIT → ISSUE (k = 0..4) → FLUSH (2 cycles) → RESP → IDLE.
- **IDLE:**
  - `req_ready` = 1.
  - On `req_valid && req_ready`, capture `req_act` and `req_wgt` into internal registers and go to INIT.
  - Inputs may change freely after acceptance.
- **INIT:** `acc_init` = 1 for exactly one cycle; `pp_data` = 0.
- **ISSUE k:**
  - Lane j of `pp_data` = `act_j` if bit k of `wgt_j` is set, else 0.
  - k increments each cycle; leave ISSUE after k = 4.
- **shift_amount:** a one-cycle-delayed copy of the issued plane index, because the adder registers data one cycle before applying the shift. It is 0 in every cycle that does not follow an ISSUE cycle.
- **FLUSH and RESP:** `pp_data` = 0, so extra adder cycles add zero.
- **Result capture:** `acc_sum` is captured into `rsp_sum` at the end of the second FLUSH cycle.
- **RESP:**
  - `rsp_valid` = 1; hold `rsp_sum` stable until `rsp_ready`.
  - Leave RESP on the cycle `rsp_valid && rsp_ready` is sampled high.
  - Accept no new request while in RESP.
- **Arithmetic:**
  - Result = Σ `act_j`·`wgt_j` mod 2^16. Activations are treated as raw 16-bit; weights are signed, −16..15.
  - Plane 4 is subtracted by the adder.
  - Wrap-around is silent; there is no saturation or overflow flag.

## Timing
Cycle numbering is relative to INIT = cycle I.

- Planes are issued in cycles I+1..I+5.
- `shift_amount` = 0, 1, 2, 3, 4 in cycles I+2..I+6.
- Accumulator is final after the edge ending I+6.
- `rsp_sum` is captured at the end of I+7.
- `rsp_valid` rises in I+8.
- Request acceptance edge to `rsp_valid` = 9 cycles.
- Minimum request spacing is 10 cycles (`rsp_ready` tied high).
- Reset values:
  - state = IDLE, `req_ready` = 1
  - `pp_data` = 0, `shift_amount` = 0, `acc_init` = 0
  - `rsp_valid` = 0, `rsp_sum` = 0
  - plane counter = 0, operand registers = 0
- Reset mid-operation:
  - Abort immediately; outputs go to their reset values asynchronously.
  - The adder is cleared by the shared reset.
  - No partial response is ever produced.
- A `req_valid` asserted while not in IDLE is ignored and is not queued.

## Structure
- **Package `engine_pkg`:**
  - Constants `LANES`, `DATA_W`, `WGT_W`, and `NUM_PLANES` (= `WGT_W`).
  - `SIGN_PLANE` = `WGT_W` − 1.
  - FSM state enum `seq_state_t` {IDLE, INIT, ISSUE, FLUSH, RESP}.
- **Sub-module `engine_plane_mask`:**
  - Combinational per-lane select of `act_j` versus 0 from bit k of `wgt_j`.
  - Instantiated once with `LANES` lanes.
- **Top level:** FSM, plane counter, delayed shift register, operand and response registers.

## Test plan
- **Basic:** `act` = {1,1,1,1}, `wgt` = {1,1,1,1} → `rsp_sum` = 0x0004; `rsp_valid` exactly 9 cycles after acceptance.
- **Signed mix:** `act` = {100,200,300,400}, `wgt` = {−16,−1,15,3} → `rsp_sum` = 3900 (0x0F3C). Check `shift_amount` sequence 0..4 lags the `pp_data` planes by one cycle.
- **Wrap-around:** all `act` = 0x7FFF, all `wgt` = 15 → `rsp_sum` = 0xFFC4.
- **Backpressure:** `rsp_ready` held low for 10 cycles → `rsp_valid` and `rsp_sum` stable, `req_ready` = 0, and a pending `req_valid` is not accepted until one cycle after the response handshake.
- **Reset mid-ISSUE (k = 2):** all outputs go to reset values. A following request (all `act` = 2, `wgt` = {1,2,3,4}) → 0x0014 with no residue from the aborted run.
- **Back-to-back:** `rsp_ready` tied high, two requests → second accepted exactly 10 cycles after the first, and both results are correct.
